// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station.
//   TAG_W / OP_W : default tag and opcode widths
//   TAG_NONE     : tag value meaning "operand already available"
//   slot_t       : one buffer slot (busy, op, vj, vk, qj, qk, imm, pc, dest_tag)
//   slot_ready() : a slot may dispatch once it is busy and both operands are present
package reservation_station_pkg;

    localparam int TAG_W  = 4;
    localparam int OP_W   = 6;
    localparam int DATA_W = 32;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [TAG_W-1:0]  dest_tag;
    } slot_t;

    function automatic logic slot_ready(input slot_t s);
        return s.busy && (s.qj == TAG_NONE) && (s.qk == TAG_NONE);
    endfunction

endpackage

// File: rtl/reservation_station_pick_lowest.sv
// rs_pick_lowest: lowest-set-bit priority encoder.
//   req   : request vector, bit i set means slot i is a candidate
//   found : at least one request bit is set
//   index : position of the lowest set bit (0 when nothing is set)
module rs_pick_lowest #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// reservation_station: out-of-order issue buffer between decode and the ALU.
//   clk_in, rst_n_in      : clock, asynchronous active-low reset
//   rdy_in                : global enable, low freezes every register
//   flush_in              : synchronous flush, empties slots and the output register
//   in_*                  : issue port (op, operand values/tags, imm, pc, dest tag)
//   full                  : no free slot, combinational from current busy bits
//   cdb_active/tag/val    : common data bus snoop
//   ex_valid/ex_ready/ex_*: registered dispatch port towards the ALU
//
// Dispatch handshake: ex_valid and ex_* come straight from registers. A
// transfer happens on a rising edge where ex_valid && ex_ready (with rdy_in
// high and no flush). While ex_valid is high and ex_ready is low, ex_* holds
// stable. The output register may be reloaded whenever it is empty or is
// being transferred in the same edge.
module reservation_station #(
    parameter int ENTRIES = 8,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  in_op,
    input  logic [31:0]      in_vj,
    input  logic [31:0]      in_vk,
    input  logic [TAG_W-1:0] in_qj,
    input  logic [TAG_W-1:0] in_qk,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_pc,
    input  logic [TAG_W-1:0] in_dest_tag,
    output logic             full,
    input  logic             cdb_active,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_val,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [OP_W-1:0]  ex_op,
    output logic [31:0]      ex_vj,
    output logic [31:0]      ex_vk,
    output logic [31:0]      ex_imm,
    output logic [31:0]      ex_pc,
    output logic [TAG_W-1:0] ex_dest_tag
);

    import reservation_station_pkg::*;

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    slot_t              slots [ENTRIES];
    logic [ENTRIES-1:0] free_vec;
    logic [ENTRIES-1:0] ready_vec;
    logic               free_found;
    logic               ready_found;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   ready_idx;
    logic               cdb_hit;
    logic               out_free;
    logic               do_insert;
    logic               do_dispatch;
    slot_t              new_slot;

    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            free_vec[i]  = !slots[i].busy;
            ready_vec[i] = slot_ready(slots[i]);
        end
    end

    rs_pick_lowest #(.N(ENTRIES), .IDX_W(IDX_W)) u_pick_free (
        .req   (free_vec),
        .found (free_found),
        .index (free_idx)
    );

    rs_pick_lowest #(.N(ENTRIES), .IDX_W(IDX_W)) u_pick_ready (
        .req   (ready_vec),
        .found (ready_found),
        .index (ready_idx)
    );

    // full looks at busy bits before this edge's dispatch, so a slot leaving
    // through the output register only becomes insertable on the next cycle.
    assign full        = !free_found;
    assign cdb_hit     = cdb_active && (cdb_tag != TAG_NONE);
    assign out_free    = !ex_valid || ex_ready;
    assign do_insert   = rdy_in && !flush_in && in_valid && free_found;
    assign do_dispatch = rdy_in && !flush_in && out_free && ready_found;

    // Incoming instruction, with operands forwarded from a CDB broadcast
    // that lands in the same cycle as the issue.
    always_comb begin
        new_slot          = '0;
        new_slot.busy     = 1'b1;
        new_slot.op       = in_op;
        new_slot.vj       = in_vj;
        new_slot.vk       = in_vk;
        new_slot.qj       = in_qj;
        new_slot.qk       = in_qk;
        new_slot.imm      = in_imm;
        new_slot.pc       = in_pc;
        new_slot.dest_tag = in_dest_tag;
        if (cdb_hit && (in_qj == cdb_tag)) begin
            new_slot.vj = cdb_val;
            new_slot.qj = TAG_NONE;
        end
        if (cdb_hit && (in_qk == cdb_tag)) begin
            new_slot.vk = cdb_val;
            new_slot.qk = TAG_NONE;
        end
    end

    // Slot storage: wakeup, dispatch release and insert. The insert target
    // is never busy, so it cannot collide with the dispatched slot.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                slots[i] <= '0;
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    slots[i].busy <= 1'b0;
                end
            end else begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (cdb_hit && slots[i].busy && (slots[i].qj == cdb_tag)) begin
                        slots[i].vj <= cdb_val;
                        slots[i].qj <= TAG_NONE;
                    end
                    if (cdb_hit && slots[i].busy && (slots[i].qk == cdb_tag)) begin
                        slots[i].vk <= cdb_val;
                        slots[i].qk <= TAG_NONE;
                    end
                    if (do_dispatch && (ready_idx == IDX_W'(i))) begin
                        slots[i].busy <= 1'b0;
                    end
                    if (do_insert && (free_idx == IDX_W'(i))) begin
                        slots[i] <= new_slot;
                    end
                end
            end
        end
    end

    // Output register towards the ALU.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ex_valid    <= 1'b0;
            ex_op       <= '0;
            ex_vj       <= '0;
            ex_vk       <= '0;
            ex_imm      <= '0;
            ex_pc       <= '0;
            ex_dest_tag <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                ex_valid <= 1'b0;
            end else if (out_free) begin
                ex_valid <= ready_found;
                if (ready_found) begin
                    ex_op       <= slots[ready_idx].op;
                    ex_vj       <= slots[ready_idx].vj;
                    ex_vk       <= slots[ready_idx].vk;
                    ex_imm      <= slots[ready_idx].imm;
                    ex_pc       <= slots[ready_idx].pc;
                    ex_dest_tag <= slots[ready_idx].dest_tag;
                end
            end
        end
    end

endmodule
